// File: rtl/demux_scan_pkg.sv
// Shared constants, state encoding and length saturation for the demux scan controller.
package demux_scan_pkg;

  localparam int LANES = 64;
  localparam int SEL_W = 6;
  localparam int LEN_W = 7;

  typedef enum logic [1:0] {IDLE, RUN, GAP} scan_state_t;

  // Lengths above the lane count collapse to one full sweep.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(LANES)) ? LEN_W'(LANES) : len;
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_demux.sv
// Combinational 1-to-64 demultiplexer: routes din onto lane sel when enabled.
module demux_1x64 (
  input  logic                              en_i,
  input  logic                              din_i,
  input  logic [demux_scan_pkg::SEL_W-1:0]  sel_i,
  output logic [demux_scan_pkg::LANES-1:0]  y_o
);

  always_comb begin
    y_o        = '0;
    y_o[sel_i] = din_i & en_i;
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Command-driven lane sequencer for the 64-lane demux bank (one registered strobe per step).
// Optional DEMUX_SCAN_REVERSE_EN adds cmd_dir to walk lanes downward.
module demux_scan_ctrl #(
  parameter int GAP = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [demux_scan_pkg::SEL_W-1:0]  cmd_start,
  input  logic [demux_scan_pkg::LEN_W-1:0]  cmd_len,
  input  logic                              cmd_din,
`ifdef DEMUX_SCAN_REVERSE_EN
  input  logic                              cmd_dir,
`endif
  input  logic                              abort,
  output logic [demux_scan_pkg::SEL_W-1:0]  sel,
  output logic [demux_scan_pkg::LANES-1:0]  y,
  output logic                              busy,
  output logic                              done
);

  import demux_scan_pkg::*;

  localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, sel_step;
  logic [LEN_W-1:0]  rem_q, rem_d, len_sat;
  logic [3:0]        gcnt_q, gcnt_d;
  logic              din_q, din_d;
  logic              done_q, done_d;
  logic [LANES-1:0]  y_q, y_d;
  logic              strobe_en;
  logic              accept;

`ifdef DEMUX_SCAN_REVERSE_EN
  logic              dir_q, dir_d;
  assign sel_step = dir_q ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
`else
  assign sel_step = sel_q + SEL_W'(1);
`endif

  assign cmd_ready = (state_q == IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign len_sat   = sat_len(cmd_len);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    din_d   = din_q;
    done_d  = 1'b0;
`ifdef DEMUX_SCAN_REVERSE_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = cmd_start;
          din_d = cmd_din;
          rem_d = len_sat;
`ifdef DEMUX_SCAN_REVERSE_EN
          dir_d = cmd_dir;
`endif
          if (len_sat == '0) done_d  = 1'b1;
          else               state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sel_d = sel_step;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = demux_scan_pkg::GAP;
            gcnt_d  = GAP_LOAD;
          end
        end
      end
      demux_scan_pkg::GAP: begin
        if (abort)               state_d = IDLE;
        else if (gcnt_q == 4'd0) state_d = RUN;
        else                     gcnt_d  = gcnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The strobe is decoded from the values being latched so it lands in the same cycle as sel.
  assign strobe_en = (state_d == RUN);

  demux_1x64 u_demux (
    .en_i  (strobe_en),
    .din_i (din_d),
    .sel_i (sel_d),
    .y_o   (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      gcnt_q  <= '0;
      din_q   <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
`ifdef DEMUX_SCAN_REVERSE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      gcnt_q  <= gcnt_d;
      din_q   <= din_d;
      done_q  <= done_d;
      y_q     <= y_d;
`ifdef DEMUX_SCAN_REVERSE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign sel  = sel_q;
  assign y    = y_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl: one instance with GAP=0, one with GAP=2, shared stimulus.
module tb_demux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_din, abort;
  logic [5:0]  cmd_start;
  logic [6:0]  cmd_len;

  logic        rdy0, busy0, done0, rdy2, busy2, done2;
  logic [5:0]  sel0, sel2;
  logic [63:0] y0, y2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_din(cmd_din),
`ifdef DEMUX_SCAN_REVERSE_EN
    .cmd_dir(1'b0),
`endif
    .abort(abort), .sel(sel0), .y(y0), .busy(busy0), .done(done0)
  );

  demux_scan_ctrl #(.GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_din(cmd_din),
`ifdef DEMUX_SCAN_REVERSE_EN
    .cmd_dir(1'b0),
`endif
    .abort(abort), .sel(sel2), .y(y2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int n);
    logic [63:0] v;
    v = '0;
    v[n % 64] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Handshake happens on the posedge inside this task (edge k); returns just after it.
  task automatic issue(input int s, input int l, input logic d);
    @(negedge clk);
    cmd_start = 6'(s);
    cmd_len   = 7'(l);
    cmd_din   = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_din = 1'b0; abort = 1'b0;
    cmd_start = '0; cmd_len = '0;
    #2;
    chk("rst.y", y0, 64'd0);
    chk("rst.sel", 64'(sel0), 64'd0);
    chk("rst.busy", 64'(busy0), 64'd0);
    chk("rst.done", 64'(done0), 64'd0);
    chk("rst.ready", 64'(rdy0), 64'd1);
    do_reset();

    issue(5, 3, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("A.y", y0, (j <= 3) ? lane(4 + j) : 64'd0);
      chk("A.done", 64'(done0), (j == 4) ? 64'd1 : 64'd0);
      chk("A.busy", 64'(busy0), (j <= 3) ? 64'd1 : 64'd0);
      if (j == 1) chk("A.sel", 64'(sel0), 64'd5);
      if (j == 4) chk("A.ready", 64'(rdy0), 64'd1);
    end

    issue(62, 4, 1'b1);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("wrap.y", y0, (j <= 4) ? lane(61 + j) : 64'd0);
      chk("wrap.done", 64'(done0), (j == 5) ? 64'd1 : 64'd0);
    end

    issue(0, 100, 1'b1);
    for (int j = 1; j <= 65; j++) begin
      @(negedge clk);
      chk("full.y", y0, (j <= 64) ? lane(j - 1) : 64'd0);
      if (j >= 64) chk("full.done", 64'(done0), (j == 65) ? 64'd1 : 64'd0);
    end

    issue(9, 0, 1'b1);
    @(negedge clk);
    chk("len0.done", 64'(done0), 64'd1);
    chk("len0.y", y0, 64'd0);
    chk("len0.busy", 64'(busy0), 64'd0);
    @(negedge clk);
    chk("len0.done2", 64'(done0), 64'd0);

    issue(4, 2, 1'b0);
    @(negedge clk);
    chk("din0.y1", y0, 64'd0);
    chk("din0.sel1", 64'(sel0), 64'd4);
    chk("din0.busy", 64'(busy0), 64'd1);
    @(negedge clk);
    chk("din0.sel2", 64'(sel0), 64'd5);
    chk("din0.y2", y0, 64'd0);
    @(negedge clk);
    chk("din0.done", 64'(done0), 64'd1);

    do_reset();
    issue(10, 3, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("gap.y", y2, (((j - 1) % 3 == 0) && j <= 7) ? lane(10 + (j - 1) / 3) : 64'd0);
      chk("gap.done", 64'(done2), (j == 8) ? 64'd1 : 64'd0);
    end

    do_reset();
    issue(20, 8, 1'b1);
    @(negedge clk);
    chk("abort.y1", y0, lane(20));
    @(negedge clk);
    chk("abort.y2", y0, lane(21));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort.y", y0, 64'd0);
    chk("abort.busy", 64'(busy0), 64'd0);
    chk("abort.done", 64'(done0), 64'd0);
    @(negedge clk);
    chk("abort.done2", 64'(done0), 64'd0);

    @(negedge clk);
    cmd_start = 6'd3; cmd_len = 7'd2; cmd_din = 1'b1;
    abort = 1'b1; cmd_valid = 1'b1;
    #1 chk("idleabort.ready", 64'(rdy0), 64'd0);
    @(posedge clk);
    #1 begin abort = 1'b0; cmd_valid = 1'b0; end
    @(negedge clk);
    chk("idleabort.busy", 64'(busy0), 64'd0);
    chk("idleabort.y", y0, 64'd0);

    issue(30, 10, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst.pre", y0, lane(31));
    rst_n = 1'b0;
    #1;
    chk("midrst.y", y0, 64'd0);
    chk("midrst.sel", 64'(sel0), 64'd0);
    chk("midrst.busy", 64'(busy0), 64'd0);
    chk("midrst.ready", 64'(rdy0), 64'd1);
    chk("midrst.done", 64'(done0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
# demux_scan_ctrl

Sequencer that drives the 1-to-64 demultiplexer fabric from a command interface. Accepts a command (start lane, lane count, data bit) over a valid/ready handshake, then walks the demux select across consecutive lanes, one registered one-hot strobe per step, wrapping modulo 64. Sits between the control plane and the 64-lane output bank. Serialises access so only one lane is ever driven in a given cycle.

## Interface
- `GAP`, default 0: idle cycles inserted between consecutive strobes (0..15).
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `cmd_valid` in, 1: command present.
- `cmd_ready` out, 1: controller can accept a command.
- `cmd_start` in, 6: first lane index.
- `cmd_len` in, 7: number of lanes to strobe.
  - 0: no-op.
  - 1..64: normal.
  - greater than 64: saturates to 64.
- `cmd_din` in, 1: value routed to each selected lane.
- `abort` in, 1: terminate the current command.
- `sel` out, 6: current demux select (registered).
- `y` out, 64: registered demux outputs. At most one bit is set.
- `busy` out, 1: high in RUN or GAP.
- `done` out, 1: one-cycle pulse when a command completes normally.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - RUN: one strobe per cycle.
  - GAP: `y`=0; counts down `GAP` cycles.
- IDLE → RUN on the `cmd_valid && cmd_ready` edge.
  - Latch `sel`=`cmd_start`, `remaining`=min(`cmd_len`,64), and `din`.
- `cmd_len`=0: go IDLE → IDLE. Pulse `done` next cycle with no strobe.
- In RUN:
  - `y` = `din` << `sel` (all zero when `din`=0). `sel` still advances.
  - Next edge: `sel`=`sel`+1 mod 64 (63 → 0), `remaining`−1.
  - If `remaining` reaches 0: go to IDLE with `done`=1. Otherwise go to GAP if `GAP`>0, else stay in RUN.
- GAP → RUN after exactly `GAP` cycles.
- `abort` high in RUN/GAP: at the next edge go to IDLE and clear `y`. `done` is not pulsed.
- `abort` in IDLE: forces `cmd_ready`=0, so no command is accepted that cycle. It has no other effect.
- `cmd_ready` is low whenever `busy` is high. Commands offered then are held by the requester (no drop).
- Reset mid-command: immediate return to IDLE. All outputs go to reset values and the command is lost.

## Timing
- Reset values:
  - `sel`=0, `y`=0, `busy`=0, `done`=0.
  - `cmd_ready`=1 once `rst_n` is high.
- Handshake on edge k, `GAP`=0, length L:
  - `y` strobes lanes `start`..`start`+L−1 during cycles k+1..k+L.
  - `done`=1 and `cmd_ready`=1 in cycle k+L+1.
  - The earliest next accept is edge k+L+1, giving a one-cycle bubble between back-to-back commands.
- With `GAP`=G:
  - Strobe i appears in cycle k+1+i·(G+1).
  - `done` appears in cycle k+1+(L−1)(G+1)+1.
- `y` and `sel` are registered, with no combinational path from inputs.

## Configuration
- `DEMUX_SCAN_REVERSE_EN` defined: adds input `cmd_dir` (1 bit, latched with the command).
  - 1: decrement `sel` (0 → 63 wrap).
  - 0: increment.
- Not defined: no `cmd_dir` port; always increment.

## Structure
- Package `demux_scan_pkg`:
  - `LANES`=64 and `SEL_W`=6 constants.
  - `LEN_W`=7 constant.
  - State enum `scan_state_t` {IDLE, RUN, GAP}.
- Sub-module: `demux_1x64` instantiated combinationally on the latched `din`/`sel`. Its output is registered into `y`.

## Test plan
- Reset with `rst_n` low mid-RUN → `y`=0, `sel`=0, `busy`=0, `cmd_ready`=1 while `rst_n`=0.
- `GAP`=0, start=5, len=3, din=1 → `y`=1<<5, 1<<6, 1<<7 on three consecutive cycles; `done` the next cycle.
- Wrap: start=62, len=4 → lanes 62, 63, 0, 1.
- len=100 from start=0 → exactly 64 strobes, every lane hit once, then `done`.
- len=0 → no strobe; `done` one cycle after the handshake.
- `GAP`=2, start=10, len=3 → strobes at cycles 1, 4, 7 after the handshake.
- `abort` during strobe 2 of len 8 → next cycle `y`=0, IDLE, no `done`.
- `abort` together with `cmd_valid` in IDLE → command not accepted.
